// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encodings
// and the default operand width.
package shift_add_multiplier_pkg;

    // Controller states; encodings are fixed so the debug port reads
    // IDLE=0, RUN=1, DONE=2.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mult_datapath.sv
// Datapath of the shift-and-add multiplier: multiplicand register M,
// accumulator {P_hi, P_lo}, the WIDTH+1-bit adder and the right shift.
// The carry bit C only exists inside one combinational add/shift step.
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_capture,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_product
);

    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_p_hi;
    logic [WIDTH-1:0]   r_p_lo;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_next_hi;
    logic [WIDTH-1:0]   w_next_lo;

    // One partial-product step: conditional add into {C,P_hi}, then shift
    // {C,P_hi,P_lo} right by one so C lands in the top bit of P_hi.
    always_comb begin
        w_sum     = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_m} : '0);
        w_next_hi = w_sum[WIDTH:1];
        w_next_lo = {w_sum[0], r_p_lo[WIDTH-1:1]};
    end

    // Operand load, step update, and result capture; capture uses the
    // post-step value because it coincides with the final step.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_m       <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_product <= '0;
        end else begin
            if (i_load) begin
                r_m    <= i_a;
                r_p_hi <= '0;
                r_p_lo <= i_b;
            end else if (i_step) begin
                r_p_hi <= w_next_hi;
                r_p_lo <= w_next_lo;
            end
            if (i_capture) begin
                r_product <= {w_next_hi, w_next_lo};
            end
        end
    end

    assign o_product = r_product;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier. The controller FSM and the
// step counter live here; the arithmetic lives in mult_datapath.
// Handshake: start is a level held by the requester until done is seen;
// done stays high (product valid and stable) until start is sampled low,
// and a new operation is only accepted from IDLE.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_e          r_state;
    logic [CW-1:0]   r_count;
    logic            r_done;
    logic            r_busy;

    logic            w_load;
    logic            w_step;
    logic            w_capture;

    // Datapath controls decoded from the current state and step count.
    always_comb begin
        w_load    = (r_state == ST_IDLE) && start;
        w_step    = (r_state == ST_RUN);
        w_capture = w_step && (r_count == LAST_STEP);
    end

    // Controller FSM with step counter and registered done/busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .i_reset   (reset),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_capture (w_capture),
        .i_a       (a),
        .i_b       (b),
        .o_product (product)
    );

    assign done      = r_done;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (WIDTH=8 and WIDTH=4).
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [7:0]  a, b;
  logic [3:0]  a4, b4;
  logic [15:0] product;
  logic [7:0]  product4;
  logic        done, busy, done4, busy4;
  logic [1:0]  state, state4;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [15:0] exp_q[$];
  int          acc_q[$];
  logic [7:0]  exp4_q[$];
  int          acc4_q[$];

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_multiplier #(.WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .product(product), .done(done), .busy(busy), .dbg_state(state)
  );

  shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .product(product4), .done(done4), .busy(busy4), .dbg_state(state4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor for the WIDTH=8 instance: product, latency, busy length, hold
  initial begin : mon8
    logic        done_d;
    int          busy_cnt;
    int          t0;
    logic [15:0] held;
    logic [15:0] e;
    done_d = 1'b0;
    busy_cnt = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      else if (done !== 1'b1) busy_cnt = 0;
      if (done === 1'b1 && !done_d) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          t0 = acc_q.pop_front();
          check("product", product, e);
          check("latency", cyc - t0, 8);
          check("busy_cycles", busy_cnt, 8);
          held = e;
        end
      end else if (done === 1'b1) begin
        check("product_hold", product, held);
      end
      done_d = (done === 1'b1);
    end
  end

  // monitor for the WIDTH=4 instance
  initial begin : mon4
    logic       done_d;
    int         t0;
    logic [7:0] e;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done4 === 1'b1 && !done_d) begin
        if (exp4_q.size() == 0) begin
          check("unexpected_done4", 1, 0);
        end else begin
          e  = exp4_q.pop_front();
          t0 = acc4_q.pop_front();
          check("product4", product4, e);
          check("latency4", cyc - t0, 4);
        end
      end
      done_d = (done4 === 1'b1);
    end
  end

  // driver: present operands with start high; record expectation at accept
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] expv);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    exp_q.push_back(expv);
    acc_q.push_back(cyc);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic release_start();
    start = 1'b0;
    @(negedge clk);
    check("done_fall", done, 0);
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // stimulus sequence
  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("reset_product", product, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_state", state, 0);
    check("reset_product4", product4, 0);
    reset = 1'b0;

    // basic product
    run_op(8'd13, 8'd11, 16'd143);
    wait_done("op_13x11");
    release_start();

    // max operands, then start held high in DONE
    run_op(8'hFF, 8'hFF, 16'hFE01);
    wait_done("op_ffxff");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("done_held", done, 1);
      check("no_retrigger_busy", busy, 0);
    end
    release_start();

    // zero multiplicand still takes the full latency
    run_op(8'd0, 8'hFF, 16'd0);
    wait_done("op_0xff");
    release_start();

    run_op(8'd3, 8'd5, 16'd15);
    wait_done("op_3x5");
    release_start();

    // operands and start disturbed during RUN
    run_op(8'd200, 8'd150, 16'd30000);
    repeat (2) @(negedge clk);
    a = 8'd0;
    b = 8'd0;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_done("op_midrun");
    repeat (3) begin
      @(negedge clk);
      check("midrun_no_second_op", busy, 0);
    end
    release_start();

    // reset in cycle 4 of RUN discards the operation
    run_op(8'd100, 8'd100, 16'd10000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_product", product, 0);
    check("midrun_reset_state", state, 0);
    reset = 1'b0;
    run_op(8'd7, 8'd9, 16'd63);
    wait_done("op_7x9");
    release_start();

    // WIDTH=4 instance
    @(negedge clk);
    a4 = 4'hF;
    b4 = 4'hF;
    start4 = 1'b1;
    @(negedge clk);
    exp4_q.push_back(8'hE1);
    acc4_q.push_back(cyc);
    begin
      int n;
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (done4 !== 1'b1) check("op4_timeout", 0, 1);
    end
    start4 = 1'b0;
    @(negedge clk);
    check("done4_fall", done4, 0);

    repeat (2) @(negedge clk);
    check("pending_expectations", exp_q.size() + exp4_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
